dt_rom_unpacker: RTL and testbench
==================================

// Module: dt_rom_unpacker
// PURPOSE
//  Front-end loader for the distance-transform datapath. Streams the packed
//  1-bit binary image from the sti ROM (16 pixels per word) and expands it into
//  one byte per pixel in the res RAM. The forward/backward pass engine then
//  operates on that RAM. Start/done handshake; also reports the foreground pixel count.
// PARAMETERS
//  IMG_W    128  image width/height in pixels (square image)
//  WORD_W   16   pixels per ROM word
//  ROM_AW   10   sti address width (IMG_W*IMG_W/WORD_W words)
//  RAM_AW   14   res address width (IMG_W*IMG_W bytes)
//  FG_VAL   1    byte written for a foreground (1) pixel; background writes 0
// PORTS
//  clk       in   1       single clock; all logic on posedge
//  reset     in   1       synchronous, active-low reset
//  start     in   1       one-cycle request to begin; sampled only in IDLE
//  busy      out  1       high from the cycle after start is accepted until done
//  done      out  1       one-cycle pulse after the last RAM write
//  sti_rd    out  1       ROM read strobe
//  sti_addr  out  ROM_AW  ROM word address
//  sti_di    in   WORD_W  ROM data; valid the cycle after sti_rd/sti_addr
//  res_wr    out  1       RAM write strobe
//  res_addr  out  RAM_AW  RAM byte address
//  res_do    out  8       RAM write data
//  fg_count  out  RAM_AW+1  count of foreground pixels; valid while done=1, held afterwards
// BEHAVIOUR
//  - Synchronous active-low reset: state=IDLE; busy, done, sti_rd, res_wr = 0;
//    sti_addr, res_addr, res_do, fg_count and the internal shift reg = 0.
//  - All outputs are registered; no combinational path from input to output.
//  - FSM: IDLE -> FETCH -> LATCH -> WRITE(x WORD_W) -> {FETCH | DONE} -> IDLE.
//    IDLE: waits for start=1; on acceptance clears word_idx and fg_count.
//    FETCH (1 cyc): sti_rd=1, sti_addr=word_idx.
//    LATCH (1 cyc): sti_rd=0; capture sti_di into the shift reg.
//    WRITE (WORD_W cyc): res_wr=1; res_addr = word_idx*WORD_W + bit_idx, where
//      bit_idx runs 0..WORD_W-1. Pixel bit_idx = sti_di[WORD_W-1-bit_idx]
//      (MSB = leftmost pixel). res_do = bit ? FG_VAL : 8'd0.
//      fg_count += bit for each written pixel.
//      After bit_idx = WORD_W-1: if word_idx = 2^ROM_AW-1 go to DONE,
//      else word_idx+1 and go to FETCH.
//    DONE (1 cyc): done=1, busy=0, res_wr=0; next state IDLE.
//  - Timing (start sampled at edge 0): word k is written in cycles
//    18k+3 .. 18k+18. The last write is in cycle 18432 and done=1 in cycle 18433.
//  - Exactly one RAM write per pixel. Each address 0..2^RAM_AW-1 is written
//    once, in ascending order. res_rd is never driven by this block.
//  - start while busy or in DONE: ignored, with no restart and no queuing.
//  - word_idx/bit_idx never wrap mid-run. The terminal check happens before
//    the increment, so sti_addr never exceeds 2^ROM_AW-1.
//  - fg_count is RAM_AW+1 bits, so 2^RAM_AW (all foreground) fits without
//    overflow. It holds its value in IDLE until the next accepted start.
//  - Reset (reset=0) mid-operation: on the next edge, return to the reset
//    state; no further ROM/RAM strobes; no done pulse. A partially written RAM
//    is left as-is.
// TESTING
//  1 all-zero ROM, start pulse -> 16384 writes of 8'd0, addrs 0..16383 in order,
//    done at cycle 18433, fg_count=0
//  2 all-ones ROM (16'hFFFF) -> every res_do=FG_VAL(1), fg_count=16384
//  3 ROM[0]=16'h8001, ROM[1023]=16'h0001, rest 0 -> RAM[0]=1, RAM[15]=1,
//    RAM[16383]=1, all others 0; fg_count=3
//  4 checkerboard ROM 16'hAAAA -> even addrs 1, odd addrs 0, fg_count=8192
//  5 start re-pulsed at cycles 100 and 18433 (DONE cycle) -> ignored; one done
//    pulse only; the run is identical to a single start
//  6 reset=0 in cycle 5000 of a run -> next cycle all outputs 0 with state IDLE;
//    a new start then completes a full run with correct fg_count

Source files
------------

// File: rtl/dt_rom_unpacker_if.sv
// Bus bundle between the distance-transform loader and its controller, ROM and RAM.
// The loader sits on the slave side; the controller/memories sit on the master side.
interface dt_rom_unpacker_if #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ROM_AW = 10,
    parameter int unsigned RAM_AW = 14
);
    logic              start;
    logic              busy;
    logic              done;
    logic              sti_rd;
    logic [ROM_AW-1:0] sti_addr;
    logic [WORD_W-1:0] sti_di;
    logic              res_wr;
    logic [RAM_AW-1:0] res_addr;
    logic [7:0]        res_do;
    logic [RAM_AW:0]   fg_count;

    modport slave (
        input  start, sti_di,
        output busy, done, sti_rd, sti_addr, res_wr, res_addr, res_do, fg_count
    );

    modport master (
        output start, sti_di,
        input  busy, done, sti_rd, sti_addr, res_wr, res_addr, res_do, fg_count
    );
endinterface

// File: rtl/dt_rom_unpacker.sv
// Expands the packed 1-bit sti ROM image into one byte per pixel in the res RAM
// and counts foreground pixels. Every output is a flop loaded from its _d value.
module dt_rom_unpacker #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ROM_AW = 10,
    parameter int unsigned RAM_AW = 14,
    parameter logic [7:0]  FG_VAL = 8'd1
) (
    input  logic                clk,
    input  logic                reset,
    dt_rom_unpacker_if.slave    bus
);
    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam int unsigned CNT_W = RAM_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] word_idx_q, word_idx_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sti_rd_q, sti_rd_d;
    logic [ROM_AW-1:0] sti_addr_q, sti_addr_d;
    logic              res_wr_q, res_wr_d;
    logic [RAM_AW-1:0] res_addr_q, res_addr_d;
    logic [7:0]        res_do_q, res_do_d;
    logic [CNT_W-1:0]  fg_count_q, fg_count_d;
    logic              pix;

    // Outputs are registered one cycle ahead: each transition loads the values
    // that belong to the state being entered.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sti_rd_d   = 1'b0;
        sti_addr_d = sti_addr_q;
        res_wr_d   = 1'b0;
        res_addr_d = res_addr_q;
        res_do_d   = res_do_q;
        fg_count_d = fg_count_q;
        pix        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_FETCH;
                    word_idx_d = '0;
                    fg_count_d = '0;
                    busy_d     = 1'b1;
                    sti_rd_d   = 1'b1;
                    sti_addr_d = '0;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // ROM data is valid now; emit the leftmost pixel straight from it.
                pix        = bus.sti_di[WORD_W-1];
                shift_d    = bus.sti_di;
                bit_idx_d  = '0;
                res_wr_d   = 1'b1;
                res_addr_d = RAM_AW'({word_idx_q, BIT_W'(0)});
                res_do_d   = pix ? FG_VAL : 8'd0;
                fg_count_d = fg_count_q + CNT_W'(pix);
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                if (bit_idx_q == BIT_W'(WORD_W - 1)) begin
                    if (word_idx_q == '1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        word_idx_d = word_idx_q + ROM_AW'(1);
                        sti_rd_d   = 1'b1;
                        sti_addr_d = word_idx_q + ROM_AW'(1);
                        state_d    = S_FETCH;
                    end
                end else begin
                    pix        = shift_q[WORD_W-2];
                    shift_d    = shift_q << 1;
                    bit_idx_d  = bit_idx_q + BIT_W'(1);
                    res_wr_d   = 1'b1;
                    res_addr_d = RAM_AW'({word_idx_q, bit_idx_q + BIT_W'(1)});
                    res_do_d   = pix ? FG_VAL : 8'd0;
                    fg_count_d = fg_count_q + CNT_W'(pix);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sti_rd_q   <= 1'b0;
            sti_addr_q <= '0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
            fg_count_q <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sti_rd_q   <= sti_rd_d;
            sti_addr_q <= sti_addr_d;
            res_wr_q   <= res_wr_d;
            res_addr_q <= res_addr_d;
            res_do_q   <= res_do_d;
            fg_count_q <= fg_count_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sti_rd   = sti_rd_q;
    assign bus.sti_addr = sti_addr_q;
    assign bus.res_wr   = res_wr_q;
    assign bus.res_addr = res_addr_q;
    assign bus.res_do   = res_do_q;
    assign bus.fg_count = fg_count_q;
endmodule

// File: tb/tb_dt_rom_unpacker.sv
// Self-checking bench for dt_rom_unpacker: a cycle-indexed reference model derives
// every expected strobe/address/data from the run's relative cycle number.
module tb_dt_rom_unpacker;
    localparam int NWORDS  = 1024;
    localparam int NPIX    = 16384;
    localparam int DONE_AT = 18433;
    localparam int RUN_CYC = 18440;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dt_rom_unpacker_if bus ();
    dt_rom_unpacker dut (.clk(clk), .reset(reset), .bus(bus));

    // Synchronous ROM: data valid the cycle after the read strobe.
    logic [15:0] rom [NWORDS];
    logic [15:0] rom_q = 16'h0;
    always @(posedge clk) if (bus.sti_rd) rom_q <= rom[bus.sti_addr];
    assign bus.sti_di = rom_q;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int failures = 0;

    // Driver-owned model inputs.
    bit run_active = 1'b0;
    bit zero_check = 1'b1;
    int run_base = 0;
    int fg_total_exp = 0;

    // Compare-owned model state.
    logic [7:0] ram [NPIX];
    int  wcnt [NPIX];
    int  fg_hold = 0;
    int  done_cnt = 0;
    int  done_rel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // Per-cycle compare, sampled 2 time units after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (zero_check) begin
                fg_hold = 0;
                chk("rst_strobes", {28'd0, bus.busy, bus.done, bus.sti_rd, bus.res_wr}, 32'd0);
                chk("rst_sti_addr", 32'(bus.sti_addr), 32'd0);
                chk("rst_res_addr", 32'(bus.res_addr), 32'd0);
                chk("rst_res_do", 32'(bus.res_do), 32'd0);
                chk("rst_fg_count", 32'(bus.fg_count), 32'd0);
            end else begin
                bit e_busy, e_done, e_rd, e_wr;
                int rel, k, p, e_sa, e_ra, e_do;
                logic [15:0] w;
                e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0;
                e_sa = 0; e_ra = 0; e_do = 0; rel = 0;
                if (run_active) begin
                    rel = edge_cnt - run_base + 1;
                    if (rel == 1) for (int a = 0; a < NPIX; a++) wcnt[a] = 0;
                    if (rel >= 1 && rel < DONE_AT) begin
                        e_busy = 1;
                        k = (rel - 1) / 18;
                        p = (rel - 1) % 18;
                        w = rom[k];
                        if (p == 0) begin e_rd = 1; e_sa = k; end
                        if (p >= 2) begin
                            e_wr = 1;
                            e_ra = 16 * k + (p - 2);
                            e_do = w[17 - p] ? 1 : 0;
                        end
                    end
                    if (rel == DONE_AT) begin
                        e_done = 1;
                        fg_hold = fg_total_exp;
                    end
                end
                chk("strobes", {28'd0, bus.busy, bus.done, bus.sti_rd, bus.res_wr},
                    {28'd0, e_busy, e_done, e_rd, e_wr});
                if (e_rd) chk("sti_addr", 32'(bus.sti_addr), 32'(e_sa));
                if (e_wr) begin
                    chk("res_addr", 32'(bus.res_addr), 32'(e_ra));
                    chk("res_do", 32'(bus.res_do), 32'(e_do));
                end
                if (!e_busy) chk("fg_count", 32'(bus.fg_count), 32'(fg_hold));
                if (bus.res_wr === 1'b1) begin
                    ram[bus.res_addr] = bus.res_do;
                    wcnt[bus.res_addr]++;
                end
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    done_rel = rel;
                end
            end
        end
    end

    function automatic int rom_popcount();
        int n = 0;
        for (int i = 0; i < NWORDS; i++)
            for (int b = 0; b < 16; b++) n += rom[i][b] ? 1 : 0;
        return n;
    endfunction

    // One start pulse, then n_cyc cycles with optional start re-pulses and mid-run reset.
    task automatic run(input int n_cyc, input int rep_a, input int rep_b, input int abort_at);
        fg_total_exp = rom_popcount();
        @(negedge clk);
        bus.start  = 1'b1;
        run_base   = edge_cnt + 1;
        run_active = 1'b1;
        for (int n = 1; n <= n_cyc; n++) begin
            @(negedge clk);
            bus.start = (n == rep_a || n == rep_b);
            if (n == abort_at) begin
                reset      = 1'b0;
                run_active = 1'b0;
                zero_check = 1'b1;
                bus.start  = 1'b0;
            end else if (n == abort_at + 1) begin
                reset      = 1'b1;
                zero_check = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_full_run(input string tag, input int done_before);
        int bad = 0;
        logic [15:0] w;
        chk({tag, "_done_pulses"}, 32'(done_cnt - done_before), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_rel), 32'(DONE_AT));
        for (int a = 0; a < NPIX; a++) begin
            w = rom[a / 16];
            if (wcnt[a] != 1 || ram[a] !== (w[15 - (a % 16)] ? 8'd1 : 8'd0)) bad++;
        end
        chk({tag, "_ram"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int db;
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < NWORDS; i++) rom[i] = 16'h0;
        repeat (3) @(negedge clk);
        reset      = 1'b1;
        zero_check = 1'b0;
        repeat (2) @(negedge clk);

        // All foreground.
        for (int i = 0; i < NWORDS; i++) rom[i] = 16'hFFFF;
        db = done_cnt;
        run(RUN_CYC, -1, -1, -1);
        check_full_run("ones", db);
        chk("ones_fg", 32'(bus.fg_count), 32'd16384);
        chk("ones_ram0", 32'(ram[0]), 32'd1);

        // Checkerboard with start re-pulsed mid-run and in the DONE cycle.
        for (int i = 0; i < NWORDS; i++) rom[i] = 16'hAAAA;
        db = done_cnt;
        run(RUN_CYC, 100, DONE_AT, -1);
        check_full_run("checker", db);
        chk("checker_fg", 32'(bus.fg_count), 32'd8192);
        chk("checker_ram0", 32'(ram[0]), 32'd1);
        chk("checker_ram1", 32'(ram[1]), 32'd0);
        chk("checker_busy_after", {31'd0, bus.busy}, 32'd0);

        // Sparse: corner pixels only.
        for (int i = 0; i < NWORDS; i++) rom[i] = 16'h0;
        rom[0]    = 16'h8001;
        rom[1023] = 16'h0001;
        db = done_cnt;
        run(RUN_CYC, -1, -1, -1);
        check_full_run("sparse", db);
        chk("sparse_fg", 32'(bus.fg_count), 32'd3);
        chk("sparse_ram0", 32'(ram[0]), 32'd1);
        chk("sparse_ram1", 32'(ram[1]), 32'd0);
        chk("sparse_ram15", 32'(ram[15]), 32'd1);
        chk("sparse_ram16382", 32'(ram[16382]), 32'd0);
        chk("sparse_ram16383", 32'(ram[16383]), 32'd1);

        // Random image, aborted by reset in cycle 5000: no done pulse.
        for (int i = 0; i < NWORDS; i++) rom[i] = 16'($urandom);
        db = done_cnt;
        run(5002, -1, -1, 5000);
        chk("abort_no_done", 32'(done_cnt - db), 32'd0);
        chk("abort_fg_cleared", 32'(bus.fg_count), 32'd0);

        // Fresh random image, full run after the abort.
        for (int i = 0; i < NWORDS; i++) rom[i] = 16'($urandom);
        db = done_cnt;
        run(RUN_CYC, -1, -1, -1);
        check_full_run("random", db);
        chk("random_fg", 32'(bus.fg_count), 32'(rom_popcount()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
